// File: rtl/clk_switch_sequencer_if.sv
// Clock-select handshake bundle between the address-decode side, the
// sequencer and the clock switcher.
interface clk_switch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             host_req;
  logic             hs_en;
  logic             hsclk_selected;
  logic             lsclk_selected;
  logic             hsclk_sel;
  logic             cpu_rdy;
  logic             switch_busy;
  logic             switch_timeout;
  logic [CNT_W-1:0] switch_count;

  modport master (
    input  host_req,
    input  hs_en,
    input  hsclk_selected,
    input  lsclk_selected,
    output hsclk_sel,
    output cpu_rdy,
    output switch_busy,
    output switch_timeout,
    output switch_count
  );

  modport slave (
    output host_req,
    output hs_en,
    output hsclk_selected,
    output lsclk_selected,
    input  hsclk_sel,
    input  cpu_rdy,
    input  switch_busy,
    input  switch_timeout,
    input  switch_count
  );
endinterface

// File: rtl/clk_switch_sequencer.sv
// Initiator side of the CPU clock-select handshake: runs the CPU on the fast
// clock when allowed and drops to the host clock for host-bus accesses.
module clk_switch_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int HS_RETURN_DELAY = 4,
  parameter int TIMEOUT_CYCLES  = 1023,
  parameter int CNT_W           = 16
) (
  input logic                    hsclk_in,
  input logic                    rst,
  clk_switch_sequencer_if.master bus
);

  localparam logic [7:0]  RETURN_LOAD = 8'(HS_RETURN_DELAY);
  localparam logic [15:0] TMO_LIMIT   = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    REQ_HS = 2'd1,
    HS_RUN = 2'd2,
    REQ_LS = 2'd3
  } state_t;

  state_t               state_r;
  logic [7:0]           delay_r;
  logic [15:0]          tmo_cnt_r;
  logic                 hsclk_sel_r;
  logic                 switch_busy_r;
  logic                 switch_timeout_r;
  logic [CNT_W-1:0]     switch_count_r;
  logic [SYNC_STAGES-1:0] hs_sync_r;
  logic [SYNC_STAGES-1:0] ls_sync_r;

  logic        hs_s;
  logic        ls_s;
  logic        hs_done_s;
  logic        ls_done_s;
  logic        leave_hs_s;
  logic [15:0] tmo_next_s;
  logic        cpu_rdy_s;

  // Feedback synchronisers for the asynchronous switcher status lines.
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      hs_sync_r <= '0;
      ls_sync_r <= '0;
    end else begin
      hs_sync_r <= {hs_sync_r[SYNC_STAGES-2:0], bus.hsclk_selected};
      ls_sync_r <= {ls_sync_r[SYNC_STAGES-2:0], bus.lsclk_selected};
    end
  end

  assign hs_s = hs_sync_r[SYNC_STAGES-1];
  assign ls_s = ls_sync_r[SYNC_STAGES-1];

  // Completion decode, saturating timeout increment and cpu_rdy lookahead.
  always_comb begin
    hs_done_s  = hs_s & ~ls_s;
    ls_done_s  = ls_s & ~hs_s;
    leave_hs_s = bus.host_req | ~bus.hs_en;
    if (tmo_cnt_r == 16'hFFFF) begin
      tmo_next_s = tmo_cnt_r;
    end else begin
      tmo_next_s = tmo_cnt_r + 16'd1;
    end
    // Dropping cpu_rdy in the HS_RUN exit cycle keeps host accesses off the fast clock.
    cpu_rdy_s = 1'b0;
    case (state_r)
      LS_RUN:  cpu_rdy_s = 1'b1;
      HS_RUN:  cpu_rdy_s = ~leave_hs_s;
      default: cpu_rdy_s = 1'b0;
    endcase
  end

  // Switch FSM with its delay/timeout counters and registered status outputs.
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state_r          <= LS_RUN;
      delay_r          <= RETURN_LOAD;
      tmo_cnt_r        <= 16'd0;
      hsclk_sel_r      <= 1'b0;
      switch_busy_r    <= 1'b0;
      switch_timeout_r <= 1'b0;
      switch_count_r   <= '0;
    end else begin
      case (state_r)
        LS_RUN: begin
          tmo_cnt_r <= 16'd0;
          if (leave_hs_s) begin
            delay_r <= RETURN_LOAD;
          end else if (delay_r == 8'd0) begin
            state_r       <= REQ_HS;
            hsclk_sel_r   <= 1'b1;
            switch_busy_r <= 1'b1;
          end else begin
            delay_r <= delay_r - 8'd1;
          end
        end
        REQ_HS: begin
          tmo_cnt_r <= tmo_next_s;
          if (tmo_next_s == TMO_LIMIT) begin
            switch_timeout_r <= 1'b1;
          end
          if (hs_done_s) begin
            state_r        <= HS_RUN;
            switch_busy_r  <= 1'b0;
            switch_count_r <= switch_count_r + CNT_W'(1);
          end
        end
        HS_RUN: begin
          tmo_cnt_r <= 16'd0;
          if (leave_hs_s) begin
            state_r       <= REQ_LS;
            hsclk_sel_r   <= 1'b0;
            switch_busy_r <= 1'b1;
          end
        end
        REQ_LS: begin
          tmo_cnt_r <= tmo_next_s;
          if (tmo_next_s == TMO_LIMIT) begin
            switch_timeout_r <= 1'b1;
          end
          if (ls_done_s) begin
            state_r        <= LS_RUN;
            delay_r        <= RETURN_LOAD;
            switch_busy_r  <= 1'b0;
            switch_count_r <= switch_count_r + CNT_W'(1);
          end
        end
        default: begin
          state_r       <= LS_RUN;
          delay_r       <= RETURN_LOAD;
          hsclk_sel_r   <= 1'b0;
          switch_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hsclk_sel      = hsclk_sel_r;
  assign bus.cpu_rdy        = cpu_rdy_s;
  assign bus.switch_busy    = switch_busy_r;
  assign bus.switch_timeout = switch_timeout_r;
  assign bus.switch_count   = switch_count_r;

endmodule
